// File: rtl/serial_fsm_pkg.sv
// Shared definitions for the serial 1-bit-stream FSM blocks: bit-order modes
// and the modular add-and-reduce helper.
package serial_fsm_pkg;

  localparam logic MODE_LSB_FIRST = 1'b0;
  localparam logic MODE_MSB_FIRST = 1'b1;

  // (a + b) mod n, valid whenever a + b < 2n (a single subtract suffices)
  function automatic logic [8:0] mod_add_reduce(input logic [8:0] a,
                                                input logic [8:0] b,
                                                input logic [8:0] n);
    logic [9:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, n}) s = s - {1'b0, n};
    return s[8:0];
  endfunction

endpackage

// File: rtl/serial_divisibility_detector_step.sv
// Combinational next-state for one serial bit: running remainder and LSB weight
// modulo DIVISOR, for either bit order.
module serial_mod_step
  import serial_fsm_pkg::*;
#(
  parameter int DIVISOR = 3,
  parameter int REM_W   = $clog2(DIVISOR)
) (
  input  logic [REM_W-1:0] r_i,
  input  logic [REM_W-1:0] w_i,
  input  logic             bit_i,
  input  logic             mode_i,
  output logic [REM_W-1:0] r_o,
  output logic [REM_W-1:0] w_o
);

  logic [8:0] r9;
  logic [8:0] w9;
  logic [8:0] n9;
  logic [8:0] r_sum;
  logic [8:0] w_sum;

  always_comb begin
    r9    = 9'(r_i);
    w9    = 9'(w_i);
    n9    = 9'(DIVISOR);
    r_sum = r9;
    w_sum = w9;
    if (mode_i == MODE_MSB_FIRST) begin
      // 2r+b computed as r + (r+b); r+b <= N so the sum stays below 2N
      r_sum = mod_add_reduce(r9, r9 + {8'd0, bit_i}, n9);
    end else begin
      r_sum = mod_add_reduce(r9, bit_i ? w9 : 9'd0, n9);
      w_sum = mod_add_reduce(w9, w9, n9);
    end
    r_o = REM_W'(r_sum);
    w_o = REM_W'(w_sum);
  end

endmodule

// File: rtl/serial_divisibility_detector.sv
// Bit-serial divisibility detector for a constant DIVISOR: registers the running
// remainder, LSB weight, bit order and accepted-bit count, one bit per valid cycle.
module serial_divisibility_detector
  import serial_fsm_pkg::*;
#(
  parameter int DIVISOR = 3,
  parameter int REM_W   = $clog2(DIVISOR),
  parameter int COUNT_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic               in_bit,
  input  logic               start,
  input  logic               last,
  input  logic               msb_first,
  output logic               out,
  output logic [REM_W-1:0]   remainder,
  output logic               out_valid,
  output logic               done,
  output logic [COUNT_W-1:0] bit_count
);

  if (DIVISOR < 2 || DIVISOR > 255) begin : g_bad_divisor
    $error("serial_divisibility_detector: DIVISOR must be in 2..255");
  end

  logic [REM_W-1:0]   r_q, r_d;
  logic [REM_W-1:0]   w_q, w_d;
  logic               mode_q, mode_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic               out_q, out_d;
  logic               out_valid_q, out_valid_d;
  logic               done_q, done_d;

  logic [REM_W-1:0]   r_base, w_base;
  logic [COUNT_W-1:0] count_base;
  logic [REM_W-1:0]   r_step, w_step;

  // start clears the frame before the bit of the same cycle is applied
  always_comb begin
    r_base     = start ? '0 : r_q;
    w_base     = start ? REM_W'(1) : w_q;
    count_base = start ? '0 : count_q;
    mode_d     = start ? msb_first : mode_q;
  end

  serial_mod_step #(
    .DIVISOR(DIVISOR),
    .REM_W  (REM_W)
  ) u_step (
    .r_i   (r_base),
    .w_i   (w_base),
    .bit_i (in_bit),
    .mode_i(mode_d),
    .r_o   (r_step),
    .w_o   (w_step)
  );

  always_comb begin
    r_d         = r_q;
    w_d         = w_q;
    count_d     = count_q;
    out_d       = out_q;
    out_valid_d = 1'b0;
    done_d      = 1'b0;
    if (in_valid) begin
      r_d         = r_step;
      w_d         = w_step;
      count_d     = (count_base == '1) ? count_base : count_base + COUNT_W'(1);
      out_d       = (r_step == '0);
      out_valid_d = 1'b1;
      done_d      = last;
    end else if (start) begin
      r_d     = '0;
      w_d     = REM_W'(1);
      count_d = '0;
      out_d   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q         <= '0;
      w_q         <= REM_W'(1);
      mode_q      <= MODE_MSB_FIRST;
      count_q     <= '0;
      out_q       <= 1'b0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      r_q         <= r_d;
      w_q         <= w_d;
      mode_q      <= mode_d;
      count_q     <= count_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      done_q      <= done_d;
    end
  end

  assign out       = out_q;
  assign remainder = r_q;
  assign out_valid = out_valid_q;
  assign done      = done_q;
  assign bit_count = count_q;

endmodule
